// File: rtl/reaction_counter_if.sv
// Command/result bundle between the reaction-timer main logic and the counter.
// Ports: CounterFlag, ErrorFlag from main logic; count, best-time and status back.
interface reaction_counter_if;
    logic [1:0]  CounterFlag;
    logic        ErrorFlag;
    logic [15:0] CountBCD;
    logic        Overflow;
    logic        Running;
    logic [15:0] BestBCD;
    logic        BestValid;
    logic        NewBest;

    // Main logic side: issues commands, reads results.
    modport master (
        output CounterFlag,
        output ErrorFlag,
        input  CountBCD,
        input  Overflow,
        input  Running,
        input  BestBCD,
        input  BestValid,
        input  NewBest
    );

    // Counter side: consumes commands, produces results.
    modport slave (
        input  CounterFlag,
        input  ErrorFlag,
        output CountBCD,
        output Overflow,
        output Running,
        output BestBCD,
        output BestValid,
        output NewBest
    );
endinterface

// File: rtl/reaction_counter.sv
// Millisecond reaction-time counter: 4-digit BCD count, sticky overflow, best time.
// Ports: clk_50M, clear_n (async active-low), bus (slave modport of reaction_counter_if).
module reaction_counter #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic               clk_50M,
    input  logic               clear_n,
    reaction_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]      BCD_MAX    = 16'h9999;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [15:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        run_q, run_d;
    logic [15:0] best_q, best_d;
    logic        bestv_q, bestv_d;
    logic        newbest_q, newbest_d;

    logic        f_clear, f_run, f_hold;
    logic        tick;
    logic        better;

    // Ripple-carry BCD increment over all four digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign f_clear = (bus.CounterFlag == 2'b00);
    assign f_run   = (bus.CounterFlag == 2'b10);
    assign f_hold  = bus.CounterFlag[0];

    assign tick = (presc_q == PRESC_LAST);

    // Valid BCD orders the same as its raw binary image.
    assign better = !bestv_q || (count_q < best_q);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        best_d    = best_q;
        bestv_d   = bestv_q;
        newbest_d = 1'b0;

        unique case (1'b1)
            f_clear: begin
                state_d = IDLE;
                presc_d = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            f_run: begin
                if (state_q != RUN) begin
                    // Every RUN entry is a fresh attempt.
                    state_d = RUN;
                    presc_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (tick) begin
                    presc_d = '0;
                    if (count_q == BCD_MAX) begin
                        ovf_d = 1'b1;
                    end else if (!ovf_q) begin
                        count_d = bcd_inc(count_q);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            f_hold: begin
                if (state_q == RUN) begin
                    state_d = HELD;
                    if (!bus.ErrorFlag && !ovf_q && better) begin
                        best_d    = count_q;
                        bestv_d   = 1'b1;
                        newbest_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            run_q     <= 1'b0;
            best_q    <= '0;
            bestv_q   <= 1'b0;
            newbest_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            run_q     <= run_d;
            best_q    <= best_d;
            bestv_q   <= bestv_d;
            newbest_q <= newbest_d;
        end
    end

    assign bus.CountBCD  = count_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Running   = run_q;
    assign bus.BestBCD   = best_q;
    assign bus.BestValid = bestv_q;
    assign bus.NewBest   = newbest_q;

endmodule

// File: tb/tb_reaction_counter.sv
// Bench for reaction_counter: elapsed-time reference model plus literal anchors.
// Ports: none (top-level bench).
module tb_reaction_counter;

    localparam int TD = 4;

    logic clk_50M;
    logic clear_n;

    reaction_counter_if bus ();

    reaction_counter #(
        .TICK_DIV (TD),
        .CNT_W    (16)
    ) dut (
        .clk_50M (clk_50M),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    int vectors = 0;
    int misses  = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Model: the count is just elapsed counting cycles / TD, clipped at 9999.
    localparam int M_IDLE = 0, M_RUN = 1, M_HELD = 2;
    int m_mode;
    int m_elapsed;
    int m_best;
    bit m_bestv;
    bit m_newbest;

    function automatic int m_ms();
        int t;
        t = m_elapsed / TD;
        return (t > 9999) ? 9999 : t;
    endfunction

    function automatic bit m_ovf();
        return (m_elapsed / TD) > 9999;
    endfunction

    always @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            m_mode    = M_IDLE;
            m_elapsed = 0;
            m_best    = 0;
            m_bestv   = 0;
            m_newbest = 0;
        end else begin
            m_newbest = 0;
            case (bus.CounterFlag)
                2'b00: begin
                    m_mode    = M_IDLE;
                    m_elapsed = 0;
                end
                2'b10: begin
                    if (m_mode != M_RUN) begin
                        m_mode    = M_RUN;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                default: begin
                    if (m_mode == M_RUN) begin
                        m_mode = M_HELD;
                        if (!bus.ErrorFlag && !m_ovf() &&
                            (!m_bestv || m_ms() < m_best)) begin
                            m_best    = m_ms();
                            m_bestv   = 1;
                            m_newbest = 1;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk_50M) begin
        chk("CountBCD",  bus.CountBCD,          to_bcd(m_ms()));
        chk("Overflow",  16'(bus.Overflow),     16'(m_ovf()));
        chk("Running",   16'(bus.Running),      16'(m_mode == M_RUN));
        chk("BestBCD",   bus.BestBCD,           to_bcd(m_best));
        chk("BestValid", 16'(bus.BestValid),    16'(m_bestv));
        chk("NewBest",   16'(bus.NewBest),      16'(m_newbest));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic run_ticks(input int n);
        bus.CounterFlag = 2'b10;
        bus.ErrorFlag   = 1'b0;
        cycles(1 + n * TD);
    endtask

    task automatic stop(input logic e);
        bus.CounterFlag = 2'b01;
        bus.ErrorFlag   = e;
        cycles(1);
    endtask

    initial begin
        clear_n         = 1'b0;
        bus.CounterFlag = 2'b00;
        bus.ErrorFlag   = 1'b0;
        cycles(3);
        chk("rst_count", bus.CountBCD, 16'h0000);
        chk("rst_best",  bus.BestBCD,  16'h0000);
        chk("rst_flags", {12'd0, bus.Overflow, bus.Running,
                          bus.BestValid, bus.NewBest}, 16'h0000);
        clear_n = 1'b1;
        cycles(2);

        // First attempt becomes the best.
        run_ticks(37);
        stop(1'b0);
        chk("t2_count",   bus.CountBCD,        16'h0037);
        chk("t2_running", 16'(bus.Running),    16'h0000);
        chk("t2_best",    bus.BestBCD,         16'h0037);
        chk("t2_bestv",   16'(bus.BestValid),  16'h0001);
        chk("t2_newbest", 16'(bus.NewBest),    16'h0001);
        cycles(1);
        chk("t2_pulse",   16'(bus.NewBest),    16'h0000);
        cycles(100);
        chk("t2_hold",    bus.CountBCD,        16'h0037);

        // Slower attempt, then faster attempt.
        bus.CounterFlag = 2'b10;
        cycles(1);
        chk("t3_entry",   bus.CountBCD,        16'h0000);
        cycles(52 * TD);
        stop(1'b0);
        chk("t3_slow",    bus.CountBCD,        16'h0052);
        chk("t3_keep",    bus.BestBCD,         16'h0037);
        chk("t3_nonew",   16'(bus.NewBest),    16'h0000);
        run_ticks(21);
        stop(1'b0);
        chk("t3_fast",    bus.BestBCD,         16'h0021);
        chk("t3_new",     16'(bus.NewBest),    16'h0001);

        // Carry ripple and saturation.
        run_ticks(999);
        chk("t4_999",     bus.CountBCD,        16'h0999);
        cycles(TD);
        chk("t4_1000",    bus.CountBCD,        16'h1000);
        cycles(9000 * TD);
        chk("t4_sat",     bus.CountBCD,        16'h9999);
        chk("t4_ovf",     16'(bus.Overflow),   16'h0001);
        cycles(3 * TD);
        chk("t4_stay",    bus.CountBCD,        16'h9999);
        stop(1'b0);
        chk("t4_nocap",   bus.BestBCD,         16'h0021);

        // Foul stop, clear, flag 11 as hold.
        run_ticks(10);
        stop(1'b1);
        chk("t5_foul",    bus.BestBCD,         16'h0021);
        bus.CounterFlag = 2'b00;
        bus.ErrorFlag   = 1'b0;
        cycles(1);
        chk("t5_clr",     bus.CountBCD,        16'h0000);
        chk("t5_clrovf",  16'(bus.Overflow),   16'h0000);
        chk("t5_retain",  bus.BestBCD,         16'h0021);
        run_ticks(3);
        bus.CounterFlag = 2'b11;
        cycles(1);
        chk("t5_11run",   16'(bus.Running),    16'h0000);
        chk("t5_11cap",   bus.BestBCD,         16'h0003);

        // Stop exactly when the prescaler sits at its last value.
        run_ticks(2);
        cycles(TD - 1);
        stop(1'b0);
        chk("t6_count",   bus.CountBCD,        16'h0002);
        chk("t6_best",    bus.BestBCD,         16'h0002);

        // Random command sequences, mostly running.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 80)      bus.CounterFlag = 2'b10;
            else if (r < 88) bus.CounterFlag = 2'b01;
            else if (r < 94) bus.CounterFlag = 2'b11;
            else             bus.CounterFlag = 2'b00;
            bus.ErrorFlag = ($urandom_range(0, 3) == 0);
            cycles(1);
        end

        // Asynchronous reset in the middle of a run.
        bus.CounterFlag = 2'b00;
        bus.ErrorFlag   = 1'b0;
        cycles(1);
        run_ticks(123);
        chk("t1_pre",     bus.CountBCD,        16'h0123);
        #1;
        clear_n = 1'b0;
        #1;
        chk("t1_count",   bus.CountBCD,        16'h0000);
        chk("t1_run",     16'(bus.Running),    16'h0000);
        chk("t1_best",    bus.BestBCD,         16'h0000);
        chk("t1_bestv",   16'(bus.BestValid),  16'h0000);
        cycles(2);
        clear_n = 1'b1;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
